mac_feeder: RTL and testbench
=============================

Name: mac_feeder

Overview:
- Sequencer and multiplier that produces the 20-bit signed product stream and 8-bit bias consumed by the neuron accumulator.
- On a start pulse it walks weight and input memories (synchronous read, 1-cycle latency) over N_IN addresses.
- It multiplies each 8-bit signed weight by a 12-bit signed input and streams registered products with first/last framing.
- It sits between the layer controller and the accumulator; the accumulator has no back-pressure, so the stream is never stalled.

Parameters:
- N_IN, 784, number of inputs per neuron (28x28 image); legal range 1..2^ADDR_W.
- ADDR_W, 10, width of the memory address outputs.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to process one neuron; honoured only in IDLE.
- bias_in  in  8  signed neuron bias, sampled on the cycle start is accepted.
- mem_rd  out  1  read enable to the weight and input memories.
- mem_addr  out  ADDR_W  shared read address for the weight and input memories.
- w_data  in  8  signed weight, valid the cycle after mem_rd.
- x_data  in  12  signed input activation, valid the cycle after mem_rd.
- prod  out  20  signed product w_data*x_data, registered.
- prod_valid  out  1  prod holds a valid product.
- first  out  1  qualifies the product for index 0; the accumulator loads the bias on this beat.
- last  out  1  qualifies the product for index N_IN-1.
- bias_out  out  8  bias latched at start, held stable until the next accepted start.
- busy  out  1  high from the cycle after start acceptance through the last beat.
- done  out  1  one-cycle pulse, the cycle after last.

Behaviour:
- Reset values:
  - All outputs are 0, including mem_addr, prod and bias_out.
  - FSM is in IDLE, address counter is 0, and all pipeline valid bits are cleared.
- FSM has four states: IDLE, RUN, DRAIN, FIN.
  - IDLE: when start=1, latch bias_in into bias_out, clear the counter, and go to RUN.
  - RUN: mem_rd=1 and mem_addr=counter. The counter increments each cycle. After issuing address N_IN-1, go to DRAIN.
  - DRAIN: mem_rd=0 and mem_addr holds its last value. Stay 2 cycles while the read stage and multiply stage empty, then go to FIN.
  - FIN: done=1 for one cycle, then return to IDLE.
- Pipeline:
  - Stage 1 is the memory read, with data arriving the cycle after mem_rd.
  - Stage 2 registers the product into prod and the valid, first and last flags travelling alongside.
- Timing, with start accepted at cycle T0:
  - Address k is issued at T1+k.
  - prod, prod_valid and first/last for index k appear at T3+k.
  - last is at T3+N_IN-1, and done at T3+N_IN.
  - busy is high from T1 through T3+N_IN-1; busy is low when done is high.
- Arithmetic:
  - Full signed 8x12 multiply, sign-extended to 20 bits. The result is exact and can never overflow (|p| <= 2^18).
  - prod holds its last value when prod_valid=0.
- Framing:
  - first and last are only ever high together with prod_valid.
  - With N_IN=1, first and last are high on the same beat.
- start outside IDLE (RUN, DRAIN, FIN) is ignored: no restart and no bias re-latch.
  - start in the same cycle as done (FIN) is also ignored.
  - start on the cycle after done is accepted.
- rst mid-operation: on the next cycle every output is at its reset value and no further prod_valid beats are emitted. In-flight products are discarded, not flushed.
- The counter never wraps during a run. N_IN = 2^ADDR_W is legal: the final address is all ones.

Test Plan:
1. N_IN=4, mem[k]: w=k+1, x=10*(k+1), bias_in=-5, start at T0.
   - mem_addr 0,1,2,3 at T1..T4.
   - prod 10,40,90,160 at T3..T6.
   - first at T3, last at T6, done at T7.
   - bias_out=-5 (0xFB) from T1.
2. Sign extremes, N_IN=2, mem[0]: w=-128, x=-2048; mem[1]: w=127, x=-2048.
   - prod = 262144 (0x40000), then -260096 (0xC0800).
3. N_IN=1, w=-3, x=7.
   - Single beat with prod=-21, first=last=prod_valid=1 at T3.
   - done at T4; busy high T1..T3 only.
4. Second start pulsed at T2 (mid-RUN) with bias_in=9, N_IN=4.
   - Ignored: exactly 4 beats, bias_out stays -5, and no new run after done.
   - A start at T8 is accepted and latches 9.
5. rst asserted at T4 of an N_IN=4 run.
   - At T5 all outputs are 0 and busy=0.
   - No prod_valid beat follows.
   - A subsequent start produces a clean 4-beat run.
6. Back-to-back runs: start asserted on the done cycle is ignored; start on the cycle after done begins a run whose first beat arrives 3 cycles later.

Source files
------------

// File: rtl/mac_feeder_if.sv
// Handshake and memory bus between the layer controller, the weight/input
// memories, mac_feeder and the neuron accumulator.
interface mac_feeder_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic [7:0]        bias_in;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        w_data;
    logic [11:0]       x_data;
    logic [19:0]       prod;
    logic              prod_valid;
    logic              first;
    logic              last;
    logic [7:0]        bias_out;
    logic              busy;
    logic              done;

    modport master (
        output start, bias_in, w_data, x_data,
        input  mem_rd, mem_addr, prod, prod_valid, first, last, bias_out, busy, done
    );

    modport slave (
        input  start, bias_in, w_data, x_data,
        output mem_rd, mem_addr, prod, prod_valid, first, last, bias_out, busy, done
    );
endinterface

// File: rtl/mac_feeder.sv
// Walks the weight/input memories for one neuron and streams registered
// signed 8x12 products with first/last framing to the accumulator.
module mac_feeder #(
    parameter int N_IN   = 784,
    parameter int ADDR_W = 10
) (
    input  logic         clk,
    input  logic         rst,
    mac_feeder_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_IN - 1);

    state_t             state_r;
    logic               drain_cnt_r;
    logic               mem_rd_r;
    logic [ADDR_W-1:0]  mem_addr_r;
    logic [7:0]         bias_r;
    logic               busy_r;
    logic               done_r;
    logic               s1_valid_r;
    logic               s1_first_r;
    logic               s1_last_r;
    logic signed [19:0] prod_r;
    logic               prod_valid_r;
    logic               first_r;
    logic               last_r;

    logic signed [19:0] product_s;
    logic               addr_last_s;
    logic               addr_first_s;

    // Exact signed product; 20 bits always hold an 8x12 result.
    always_comb begin
        product_s    = $signed({{12{bus.w_data[7]}}, bus.w_data})
                     * $signed({{8{bus.x_data[11]}}, bus.x_data});
        addr_last_s  = (mem_addr_r == LAST_ADDR);
        addr_first_s = (mem_addr_r == {ADDR_W{1'b0}});
    end

    // Sequencer: address generation, drain wait, done pulse and bias latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            drain_cnt_r <= 1'b0;
            mem_rd_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            bias_r      <= 8'h00;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        bias_r     <= bus.bias_in;
                        mem_addr_r <= {ADDR_W{1'b0}};
                        mem_rd_r   <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= RUN;
                    end
                end
                RUN: begin
                    // The address register is the counter; it stops at the
                    // final address so it never wraps, even at 2^ADDR_W.
                    if (addr_last_s) begin
                        mem_rd_r    <= 1'b0;
                        drain_cnt_r <= 1'b0;
                        state_r     <= DRAIN;
                    end else begin
                        mem_addr_r <= mem_addr_r + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt_r) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= FIN;
                    end else begin
                        drain_cnt_r <= 1'b1;
                    end
                end
                FIN: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    mem_rd_r <= 1'b0;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    // Read stage flags follow the issued address; multiply stage registers the product.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r   <= 1'b0;
            s1_first_r   <= 1'b0;
            s1_last_r    <= 1'b0;
            prod_r       <= 20'sd0;
            prod_valid_r <= 1'b0;
            first_r      <= 1'b0;
            last_r       <= 1'b0;
        end else begin
            s1_valid_r   <= mem_rd_r;
            s1_first_r   <= mem_rd_r & addr_first_s;
            s1_last_r    <= mem_rd_r & addr_last_s;
            prod_valid_r <= s1_valid_r;
            first_r      <= s1_first_r;
            last_r       <= s1_last_r;
            if (s1_valid_r) begin
                prod_r <= product_s;
            end
        end
    end

    assign bus.mem_rd     = mem_rd_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.prod       = prod_r;
    assign bus.prod_valid = prod_valid_r;
    assign bus.first      = first_r;
    assign bus.last       = last_r;
    assign bus.bias_out   = bias_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder: three instances (N_IN = 4, 2, 1) with
// behavioural memories, checked cycle by cycle against hand-derived timing.
module tb_mac_feeder;
    logic       clk;
    logic       rst;
    logic       start_s;
    logic [7:0] bias_s;
    logic [1:0] sel;

    int vectors;
    int miscompares;

    logic [19:0] exp_prod [0:3];
    logic [19:0] hold_r   [0:2];

    mac_feeder_if #(.ADDR_W(10)) ifa ();
    mac_feeder_if #(.ADDR_W(10)) ifb ();
    mac_feeder_if #(.ADDR_W(10)) ifc ();

    mac_feeder #(.N_IN(4), .ADDR_W(10)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    mac_feeder #(.N_IN(2), .ADDR_W(10)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    mac_feeder #(.N_IN(1), .ADDR_W(10)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    assign ifa.start   = start_s && (sel == 2'd0);
    assign ifb.start   = start_s && (sel == 2'd1);
    assign ifc.start   = start_s && (sel == 2'd2);
    assign ifa.bias_in = bias_s;
    assign ifb.bias_in = bias_s;
    assign ifc.bias_in = bias_s;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memories: synchronous read, data one cycle after mem_rd.
    always @(posedge clk) begin
        if (ifa.mem_rd) begin
            ifa.w_data <= 8'(ifa.mem_addr + 10'd1);
            ifa.x_data <= 12'(10 * (ifa.mem_addr + 10'd1));
        end
        if (ifb.mem_rd) begin
            ifb.w_data <= (ifb.mem_addr == 10'd0) ? 8'h80 : 8'h7F;
            ifb.x_data <= 12'h800;
        end
        if (ifc.mem_rd) begin
            ifc.w_data <= 8'hFD;
            ifc.x_data <= 12'd7;
        end
    end

    logic        o_rd, o_valid, o_first, o_last, o_busy, o_done;
    logic [9:0]  o_addr;
    logic [19:0] o_prod;
    logic [7:0]  o_bias;

    always_comb begin
        case (sel)
            2'd0: begin
                o_rd = ifa.mem_rd; o_addr = ifa.mem_addr; o_prod = ifa.prod;
                o_valid = ifa.prod_valid; o_first = ifa.first; o_last = ifa.last;
                o_bias = ifa.bias_out; o_busy = ifa.busy; o_done = ifa.done;
            end
            2'd1: begin
                o_rd = ifb.mem_rd; o_addr = ifb.mem_addr; o_prod = ifb.prod;
                o_valid = ifb.prod_valid; o_first = ifb.first; o_last = ifb.last;
                o_bias = ifb.bias_out; o_busy = ifb.busy; o_done = ifb.done;
            end
            default: begin
                o_rd = ifc.mem_rd; o_addr = ifc.mem_addr; o_prod = ifc.prod;
                o_valid = ifc.prod_valid; o_first = ifc.first; o_last = ifc.last;
                o_bias = ifc.bias_out; o_busy = ifc.busy; o_done = ifc.done;
            end
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag, input int t);
        chk({tag, "_rd"},    t, 32'(o_rd),    32'd0);
        chk({tag, "_addr"},  t, 32'(o_addr),  32'd0);
        chk({tag, "_prod"},  t, 32'(o_prod),  32'd0);
        chk({tag, "_valid"}, t, 32'(o_valid), 32'd0);
        chk({tag, "_first"}, t, 32'(o_first), 32'd0);
        chk({tag, "_last"},  t, 32'(o_last),  32'd0);
        chk({tag, "_bias"},  t, 32'(o_bias),  32'd0);
        chk({tag, "_busy"},  t, 32'(o_busy),  32'd0);
        chk({tag, "_done"},  t, 32'(o_done),  32'd0);
    endtask

    // Accept a start at T0 then check every output from T1 to T(n+4).
    // extra_t > 0 pulses a further start (with extra_bias) during cycle extra_t.
    task automatic run_check(input int n, input logic [7:0] bias_v,
                             input int extra_t, input logic [7:0] extra_bias);
        logic [19:0] pe;
        logic        ve;
        start_s = 1'b1;
        bias_s  = bias_v;
        step();
        start_s = 1'b0;
        bias_s  = 8'h00;
        for (int t = 1; t <= n + 4; t++) begin
            ve = (t >= 3) && (t <= n + 2);
            if (ve)          pe = exp_prod[t-3];
            else if (t < 3)  pe = hold_r[sel];
            else             pe = exp_prod[n-1];
            chk("mem_rd",     t, 32'(o_rd),    32'((t >= 1) && (t <= n)));
            chk("mem_addr",   t, 32'(o_addr),  (t <= n) ? 32'(t - 1) : 32'(n - 1));
            chk("prod_valid", t, 32'(o_valid), 32'(ve));
            chk("prod",       t, 32'(o_prod),  32'(pe));
            chk("first",      t, 32'(o_first), 32'(t == 3));
            chk("last",       t, 32'(o_last),  32'(t == n + 2));
            chk("busy",       t, 32'(o_busy),  32'(t <= n + 2));
            chk("done",       t, 32'(o_done),  32'(t == n + 3));
            chk("bias_out",   t, 32'(o_bias),  32'(bias_v));
            if (t == extra_t) begin
                start_s = 1'b1;
                bias_s  = extra_bias;
            end else begin
                start_s = 1'b0;
            end
            if (t < n + 4) step();
        end
        start_s = 1'b0;
        hold_r[sel] = exp_prod[n-1];
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        sel         = 2'd0;
        start_s     = 1'b0;
        bias_s      = 8'h00;
        hold_r[0]   = 20'd0;
        hold_r[1]   = 20'd0;
        hold_r[2]   = 20'd0;
        rst         = 1'b1;
        step();
        step();
        chk_idle_zero("reset", 0);
        rst = 1'b0;
        step();

        // N_IN=4, w=k+1, x=10(k+1): products 10, 40, 90, 160.
        exp_prod[0] = 20'd10;
        exp_prod[1] = 20'd40;
        exp_prod[2] = 20'd90;
        exp_prod[3] = 20'd160;
        run_check(4, 8'hFB, 0, 8'h00);
        step();

        // Mid-run start with bias 9 ignored; start at T8 accepted and latches 9.
        run_check(4, 8'hFB, 2, 8'h09);
        // Start on the done cycle ignored; start the cycle after done accepted.
        run_check(4, 8'h09, 7, 8'h33);
        run_check(4, 8'h22, 0, 8'h00);
        step();

        // Reset at T4: everything zero at T5, no further beats.
        start_s = 1'b1;
        bias_s  = 8'hFB;
        step();
        start_s = 1'b0;
        step();
        step();
        step();
        chk("rst_pre_valid", 4, 32'(o_valid), 32'd1);
        chk("rst_pre_prod",  4, 32'(o_prod),  32'd40);
        rst = 1'b1;
        step();
        chk_idle_zero("rst_mid", 5);
        rst = 1'b0;
        for (int t = 6; t <= 9; t++) begin
            step();
            chk("rst_after_valid", t, 32'(o_valid), 32'd0);
            chk("rst_after_busy",  t, 32'(o_busy),  32'd0);
        end
        hold_r[0] = 20'd0;
        run_check(4, 8'hFB, 0, 8'h00);
        step();

        // Sign extremes, N_IN=2: 0x40000 then 0xC0800.
        sel = 2'd1;
        exp_prod[0] = 20'h40000;
        exp_prod[1] = 20'hC0800;
        run_check(2, 8'h7F, 0, 8'h00);
        step();

        // N_IN=1, w=-3, x=7: single beat of -21 with first and last together.
        sel = 2'd2;
        exp_prod[0] = 20'hFFFEB;
        run_check(1, 8'h80, 0, 8'h00);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
